// File: rtl/ddr_bridge_pkg.sv
// Shared types and constants for the DDR bridge: bus widths, FSM state
// encoding and the bit positions of the sticky error flags.
package ddr_bridge_pkg;

    localparam int DdrAddrWidth = 32;
    localparam int DdrDataWidth = 32;

    typedef logic [DdrAddrWidth-1:0] ddr_address_t;
    typedef logic [DdrDataWidth-1:0] ddr_data_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } ddr_bridge_state_t;

    localparam int unsigned BridgeErrTimeout  = 0;
    localparam int unsigned BridgeErrConflict = 1;
    localparam int unsigned BridgeErrStray    = 2;

    // States in which a transaction is in flight and the watchdog runs.
    function automatic logic is_req_or_wait(input ddr_bridge_state_t s);
        return (s == ST_RD_REQ) || (s == ST_RD_WAIT) ||
               (s == ST_WR_REQ) || (s == ST_WR_WAIT);
    endfunction

endpackage

// File: rtl/ddr_bridge_if.sv
// Requester-side enable/done signals and memory-side valid/ready channel
// of the DDR bridge, bundled so the bridge and its environment share one view.
interface ddr_bridge_if;
    import ddr_bridge_pkg::*;

    // Requester side
    ddr_address_t ddr_address_i;
    logic         ddr_w_en_i;
    ddr_data_t    ddr_w_data_i;
    logic         ddr_w_done_o;
    logic         ddr_r_en_i;
    ddr_data_t    ddr_r_data_o;
    logic         ddr_r_valid_o;

    // Memory side: a request transfers when valid and ready are both high
    // on a rising edge; the response/ack is a separate one-cycle strobe.
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic         mem_req_write_o;
    ddr_address_t mem_req_addr_o;
    ddr_data_t    mem_req_wdata_o;
    logic         mem_rsp_valid_i;
    ddr_data_t    mem_rsp_data_i;
    logic         mem_wr_ack_i;

    // Environment view: drives requests and the memory, observes the bridge.
    modport master (
        output ddr_address_i, ddr_w_en_i, ddr_w_data_i, ddr_r_en_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_wr_ack_i,
        input  ddr_w_done_o, ddr_r_data_o, ddr_r_valid_o,
        input  mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_wdata_o
    );

    // Bridge view.
    modport slave (
        input  ddr_address_i, ddr_w_en_i, ddr_w_data_i, ddr_r_en_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_wr_ack_i,
        output ddr_w_done_o, ddr_r_data_o, ddr_r_valid_o,
        output mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_wdata_o
    );

endinterface

// File: rtl/watchdog_counter.sv
// Cycle counter that flags the last permitted cycle of a transaction so the
// owner can force completion on the following edge.
module watchdog_counter #(
    parameter int Limit = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CntW = $clog2(Limit);
    localparam logic [CntW-1:0] LastCount = CntW'(Limit - 2);

    logic [CntW-1:0] r_count;

    // Saturates rather than wraps so a stuck owner cannot see a second expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= '0;
        end else if (enable_i && (r_count != {CntW{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count k is held during the (k+1)-th busy cycle; firing at Limit-2 means
    // the owner completes after Limit-1 busy cycles.
    assign expired_o = enable_i && (r_count == LastCount);

endmodule

// File: rtl/ddr_bridge.sv
// Converts matrix_unit's level-held DDR enables into a single-outstanding
// valid/ready memory request, returning one-cycle done/valid pulses.
module ddr_bridge
    import ddr_bridge_pkg::*;
#(
    parameter int TimeoutCycles = 4096  // must be at least 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ddr_bridge_if.slave       bus,
    output logic              busy_o,
    output logic [2:0]        err_o,
    output ddr_bridge_state_t state_o
);

    ddr_bridge_state_t r_state;
    ddr_bridge_state_t w_next_state;

    logic         r_is_write;
    ddr_address_t r_addr;
    ddr_data_t    r_wdata;
    logic         r_req_valid;
    logic         r_r_valid;
    logic         r_w_done;
    ddr_data_t    r_r_data;
    logic         r_busy;
    logic [2:0]   r_err;

    logic w_expired;
    logic w_timeout;
    logic w_issue;
    logic w_conflict;
    logic w_stray;
    logic w_resp_next;
    logic w_req_next;

    watchdog_counter #(
        .Limit (TimeoutCycles)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (r_state == ST_IDLE),
        .enable_i  (is_req_or_wait(r_state)),
        .expired_o (w_expired)
    );

    // In REQ the watchdog beats ready, so an accepted-but-abandoned request
    // leaves any later reply to be flagged as stray; in WAIT a real reply wins.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ddr_w_en_i) begin
                    w_next_state = ST_WR_REQ;
                end else if (bus.ddr_r_en_i) begin
                    w_next_state = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (w_expired) begin
                    w_next_state = ST_RESP;
                    w_timeout    = 1'b1;
                end else if (bus.mem_req_ready_i) begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.mem_rsp_valid_i) begin
                    w_next_state = ST_RESP;
                end else if (w_expired) begin
                    w_next_state = ST_RESP;
                    w_timeout    = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (w_expired) begin
                    w_next_state = ST_RESP;
                    w_timeout    = 1'b1;
                end else if (bus.mem_req_ready_i) begin
                    w_next_state = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (bus.mem_wr_ack_i) begin
                    w_next_state = ST_RESP;
                end else if (w_expired) begin
                    w_next_state = ST_RESP;
                    w_timeout    = 1'b1;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_issue     = (r_state == ST_IDLE) && (bus.ddr_w_en_i || bus.ddr_r_en_i);
    assign w_conflict  = (r_state == ST_IDLE) && bus.ddr_w_en_i && bus.ddr_r_en_i;
    assign w_stray     = (bus.mem_rsp_valid_i && (r_state != ST_RD_WAIT)) ||
                         (bus.mem_wr_ack_i    && (r_state != ST_WR_WAIT));
    assign w_resp_next = (w_next_state == ST_RESP);
    assign w_req_next  = (w_next_state == ST_RD_REQ) || (w_next_state == ST_WR_REQ);

    // Every output is computed from next-state decode and registered here,
    // so nothing on the outputs depends combinationally on an input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_valid <= 1'b0;
            r_r_valid   <= 1'b0;
            r_w_done    <= 1'b0;
            r_r_data    <= '0;
            r_busy      <= 1'b0;
            r_err       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_req_valid <= w_req_next;
            r_r_valid   <= w_resp_next && !r_is_write;
            r_w_done    <= w_resp_next && r_is_write;
            r_busy      <= (w_next_state != ST_IDLE);

            if (w_issue) begin
                r_is_write <= bus.ddr_w_en_i;
                r_addr     <= bus.ddr_address_i;
                if (bus.ddr_w_en_i) begin
                    r_wdata <= bus.ddr_w_data_i;
                end
            end

            if ((r_state == ST_RD_WAIT) && bus.mem_rsp_valid_i) begin
                r_r_data <= bus.mem_rsp_data_i;
            end else if (w_timeout && !r_is_write) begin
                r_r_data <= '0;
            end

            if (w_timeout) begin
                r_err[BridgeErrTimeout] <= 1'b1;
            end
            if (w_conflict) begin
                r_err[BridgeErrConflict] <= 1'b1;
            end
            if (w_stray) begin
                r_err[BridgeErrStray] <= 1'b1;
            end
        end
    end

    assign bus.mem_req_valid_o = r_req_valid;
    assign bus.mem_req_write_o = r_is_write;
    assign bus.mem_req_addr_o  = r_addr;
    assign bus.mem_req_wdata_o = r_wdata;
    assign bus.ddr_r_valid_o   = r_r_valid;
    assign bus.ddr_r_data_o    = r_r_data;
    assign bus.ddr_w_done_o    = r_w_done;
    assign busy_o              = r_busy;
    assign err_o               = r_err;
    assign state_o             = r_state;

endmodule

// File: doc/ddr_bridge.md
# ddr_bridge

Sits directly downstream of `matrix_unit` on its DDR port and converts the unit's level-held enable/done interface into a valid/ready memory request channel. It has a separate response channel. The bridge serialises traffic to one outstanding transaction, registers all memory-side outputs and returns read data and write completions as single-cycle pulses. A watchdog converts a hung memory into a completed transaction plus a sticky error, so the unit never deadlocks.

## Interface
Parameters:
- `TimeoutCycles`, 4096: cycles a transaction may spend in a request or wait state before it is force-completed; ≥ 4.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `ddr_address_i`  in  `ddr_address_t`  request address from `matrix_unit`
- `ddr_w_en_i`  in  1  write request; held with address and data until `ddr_w_done_o`
- `ddr_w_data_i`  in  `ddr_data_t`  write data
- `ddr_w_done_o`  out  1  one-cycle write completion pulse
- `ddr_r_en_i`  in  1  read request; held with address until `ddr_r_valid_o`
- `ddr_r_data_o`  out  `ddr_data_t`  read data; valid only with `ddr_r_valid_o`
- `ddr_r_valid_o`  out  1  one-cycle read data pulse
- `mem_req_valid_o`  out  1  memory request valid
- `mem_req_ready_i`  in  1  memory accepts the request this cycle
- `mem_req_write_o`  out  1  1 = write, 0 = read
- `mem_req_addr_o`  out  `ddr_address_t`  memory address
- `mem_req_wdata_o`  out  `ddr_data_t`  memory write data
- `mem_rsp_valid_i`  in  1  read response valid
- `mem_rsp_data_i`  in  `ddr_data_t`  read response data
- `mem_wr_ack_i`  in  1  write acknowledge
- `busy_o`  out  1  state ≠ IDLE
- `err_o`  out  3  sticky flags: [0] timeout, [1] r/w conflict, [2] stray response

## Operation
- FSM states are IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE:
  - `ddr_w_en_i` set → latch address and data, go to WR_REQ.
  - Otherwise `ddr_r_en_i` set → latch address, go to RD_REQ.
  - Both set → the write wins and `err_o[1]` is set.
- RD_REQ / WR_REQ:
  - `mem_req_valid_o` = 1 and the latched fields are driven.
  - On `mem_req_ready_i`, go to RD_WAIT or WR_WAIT.
  - Fields stay stable while ready is low.
- RD_WAIT: on `mem_rsp_valid_i`, capture `mem_rsp_data_i` into `ddr_r_data_o`, then go to RESP (read flavour).
- WR_WAIT: on `mem_wr_ack_i`, go to RESP (write flavour).
- RESP lasts one cycle:
  - Read flavour drives `ddr_r_valid_o` = 1; write flavour drives `ddr_w_done_o` = 1.
  - Next state is IDLE, unconditionally.
- Inputs are ignored outside IDLE. Request inputs changing mid-transaction have no effect.
- Watchdog:
  - The counter clears on leaving IDLE and increments every cycle in REQ/WAIT.
  - At `TimeoutCycles`−1 the FSM goes to RESP. Read data is forced to 0, `err_o[0]` is set and `mem_req_valid_o` drops.
- Any `mem_rsp_valid_i` outside RD_WAIT, or `mem_wr_ack_i` outside WR_WAIT, is ignored and sets `err_o[2]`. This includes late responses after a timeout.
- The `err_o` bits clear only on reset.

## Timing
- Reset value of all outputs is 0, including `ddr_r_data_o` and `err_o`. The FSM resets to IDLE.
- Reset mid-transaction abandons the transaction immediately. A memory response arriving after reset counts as stray.
- All outputs are registered; there is no combinational input→output path.
- Read latency with request seen in IDLE at cycle 0:
  - `mem_req_valid_o` at cycle 1.
  - Ready at cycle 1 → RD_WAIT at cycle 2.
  - Response at cycle k ≥ 2 → `ddr_r_valid_o` at cycle k+1.
  - Minimum is 3 cycles; writes are identical.
- The requester must drop or replace its enable in the cycle after the done/valid pulse. IDLE samples again in the cycle after RESP, so back-to-back issue gaps are 0 cycles beyond the pulse.
- Memory must not respond in the same cycle it accepts; such a response is treated as stray.

## Structure
- `config_pkg` additions:
  - `ddr_bridge_state_t` enum.
  - `BridgeErrTimeout`, `BridgeErrConflict`, `BridgeErrStray` bit-index constants.
- `ddr_address_t` and `ddr_data_t` are reused from `config_pkg`.
- One sub-module, `watchdog_counter`, with a clear/enable input, parameterised limit and one-cycle `expired_o`.

## Test plan
- Read addr 0x40, ready immediate, response at cycle 2 with 0xDEADBEEF → `ddr_r_valid_o` at cycle 3 with that data; `err_o` = 0.
- Write addr 0x80 data 0x1234, ready held low 5 cycles → `mem_req_valid_o` and fields stable for 6 cycles; `ddr_w_done_o` one cycle after ack.
- `ddr_r_en_i` and `ddr_w_en_i` both high → write issued first, `err_o` = 3'b010; after the write completes, the still-held read is issued.
- `TimeoutCycles` = 8, no response → `ddr_r_valid_o` with data 0 at cycle 8, `err_o[0]` = 1; a later response sets `err_o[2]`.
- Reset asserted during RD_WAIT → next cycle all outputs 0 and IDLE; a subsequent response sets only `err_o[2]`.
- 100 random back-to-back reads and writes with random ready/latency against a memory model → data matches and each request gets exactly one pulse.
